gr_file_sb: RTL and testbench



---
 rtl/gr_file_sb.sv | 120 ++++++++++++
 tb/tb_gr_file_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gr_file_sb.sv
// ============================================================================
// Module   : gr_file_sb
// Purpose  : V850 general-register file with per-register write-pending
//            scoreboard, multi-port read/write and optional write bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gr_file_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic [NWR-1:0]        wr_en_i,
  input  logic [NWR*AW-1:0]     wr_addr_i,
  input  logic [NWR*DATA_W-1:0] wr_data_i,
  input  logic                  iss_en_i,
  input  logic [AW-1:0]         iss_addr_i,
  output logic                  iss_ready_o,
  input  logic                  flush_i,
  output logic [NREGS-1:0]      busy_mask_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic              iss_acc;

  // Register array; ascending port loop lets the highest port win on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign iss_ready_o = (iss_addr_i == '0) || (cnt[iss_addr_i] != CNT_MAX);
  assign iss_acc     = iss_en_i && iss_ready_o && !flush_i;

  assign cnt[0]         = '0;
  assign busy_mask_o[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREGS; r++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_nxt;
      int               net;

      // Net change of issue and all write retirements, clamped at zero.
      always_comb begin
        net = int'(cnt_q);
        if (iss_acc && (iss_addr_i == AW'(r))) net = net + 1;
        for (int w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(r))) net = net - 1;
        end
        if (net < 0) net = 0;
        cnt_nxt = flush_i ? '0 : CNT_W'(net);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_nxt;
      end

      assign cnt[r]         = cnt_q;
      assign busy_mask_o[r] = (cnt_q != '0);
    end
  endgenerate

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic              busy;
      int                nw;

      assign addr = rd_addr_i[p*AW +: AW];

      always_comb begin
        data = regs[addr];
        nw   = 0;
        for (int w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == addr)) begin
            if (BYPASS != 0) data = wr_data_i[w*DATA_W +: DATA_W];
            nw = nw + 1;
          end
        end
        if (BYPASS != 0) busy = (int'(cnt[addr]) > nw);
        else             busy = (cnt[addr] != '0);
        if (addr == '0) begin
          data = '0;
          busy = 1'b0;
        end
      end

      assign rd_data_o[p*DATA_W +: DATA_W] = data;
      assign rd_busy_o[p]                  = busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_gr_file_sb.sv
// ============================================================================
// Module   : tb_gr_file_sb
// Purpose  : Scoreboard bench for gr_file_sb against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gr_file_sb;

  localparam int AW = 5;

  logic        clk;
  logic        rst_n;
  logic [14:0] rd_addr_i;
  logic [95:0] rd_data_o;
  logic [2:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        iss_en_i;
  logic [4:0]  iss_addr_i;
  logic        iss_ready_o;
  logic        flush_i;
  logic [31:0] busy_mask_o;

  gr_file_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .iss_ready_o(iss_ready_o),
    .flush_i    (flush_i),
    .busy_mask_o(busy_mask_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          tag;
    logic [95:0] data;
    logic [2:0]  busy;
    logic        ready;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          tag_cnt    = 0;
  logic [31:0] mem  [32];
  int          pend [32];

  task automatic chk(input string nm, input int tag, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, tag, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 0;
    end
  endtask

  // One cycle: drive, predict this cycle's outputs, then advance the model.
  task automatic step(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic ie, input logic [4:0] ia, input logic fl);
    exp_t        e;
    logic [4:0]  ra [3];
    logic [31:0] d;
    int          nw, n;
    logic        acc;
    @(posedge clk);
    #1;
    rd_addr_i  = {ra2, ra1, ra0};
    wr_en_i    = we;
    wr_addr_i  = {wa1, wa0};
    wr_data_i  = {wd1, wd0};
    iss_en_i   = ie;
    iss_addr_i = ia;
    flush_i    = fl;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    e.tag = tag_cnt++;
    for (int q = 0; q < 3; q++) begin
      d  = mem[ra[q]];
      nw = 0;
      if (we[0] && wa0 == ra[q]) begin d = wd0; nw++; end
      if (we[1] && wa1 == ra[q]) begin d = wd1; nw++; end
      if (ra[q] == 0) d = 0;
      e.data[q*32 +: 32] = d;
      e.busy[q] = (ra[q] != 0) && (pend[ra[q]] - nw > 0);
    end
    e.ready = (ia == 0) || (pend[ia] < 3);
    for (int i = 0; i < 32; i++) e.mask[i] = (pend[i] > 0);
    sb.push_back(e);
    acc = ie && e.ready && !fl;
    if (we[0] && wa0 != 0) mem[wa0] = wd0;
    if (we[1] && wa1 != 0) mem[wa1] = wd1;
    for (int i = 1; i < 32; i++) begin
      n = pend[i];
      if (acc && ia == i) n++;
      if (we[0] && wa0 == i) n--;
      if (we[1] && wa1 == i) n--;
      if (n < 0) n = 0;
      pend[i] = fl ? 0 : n;
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    step(a0, a1, a2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic iss(input logic [4:0] a, input logic [4:0] r0);
    step(r0, a, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, a, 1'b0);
  endtask

  task automatic reset_check(input string nm);
    chk({nm, "_data"},  -1, rd_data_o,   96'h0);
    chk({nm, "_busy"},  -1, rd_busy_o,   3'b000);
    chk({nm, "_mask"},  -1, busy_mask_o, 32'h0);
    chk({nm, "_ready"}, -1, iss_ready_o, 1'b1);
  endtask

  // Async reset pulse between edges; outputs must clear without a clock.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    wr_en_i    = 2'b00;
    iss_en_i   = 1'b0;
    flush_i    = 1'b0;
    iss_addr_i = 5'd3;
    rd_addr_i  = {5'd7, 5'd2, 5'd5};
    rst_n      = 1'b0;
    #1;
    reset_check("async_rst");
    model_clear();
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are sampled mid-cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data",   e.tag, rd_data_o,   e.data);
        chk("rd_busy",   e.tag, rd_busy_o,   e.busy);
        chk("iss_ready", e.tag, iss_ready_o, e.ready);
        chk("busy_mask", e.tag, busy_mask_o, e.mask);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    rd_addr_i  = {5'd3, 5'd7, 5'd5};
    wr_en_i    = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    iss_en_i   = 1'b0;
    iss_addr_i = 5'd7;
    flush_i    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_check("in_reset");
    rst_n = 1'b1;

    // r0 behaviour
    step(5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    rd(5'd0, 5'd0, 5'd0);
    // port priority with same-cycle bypass
    step(5'd5, 5'd5, 5'd0, 2'b11, 5'd5, 32'h12345678, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    rd(5'd5, 5'd0, 5'd5);
    // hazard lifecycle on r7
    iss(5'd7, 5'd7);
    rd(5'd7, 5'd7, 5'd0);
    rd(5'd7, 5'd0, 5'd0);
    step(5'd7, 5'd7, 5'd0, 2'b01, 5'd7, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    rd(5'd7, 5'd0, 5'd0);
    // saturation on r3
    repeat (4) iss(5'd3, 5'd3);
    rd(5'd3, 5'd0, 5'd0);
    repeat (3) step(5'd3, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'd3, $urandom, 1'b0, 5'd0, 1'b0);
    rd(5'd3, 5'd0, 5'd0);
    // r9 net change and double retire
    iss(5'd9, 5'd9);
    step(5'd9, 5'd0, 5'd0, 2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    rd(5'd9, 5'd0, 5'd0);
    step(5'd9, 5'd0, 5'd0, 2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 1'b0);
    rd(5'd9, 5'd0, 5'd0);
    // flush with concurrent issue and write
    iss(5'd1, 5'd0);
    iss(5'd2, 5'd0);
    iss(5'd4, 5'd0);
    step(5'd6, 5'd2, 5'd1, 2'b01, 5'd2, 32'hAA, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1);
    rd(5'd6, 5'd2, 5'd4);
    step(5'd1, 5'd0, 5'd0, 2'b01, 5'd1, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    rd(5'd1, 5'd2, 5'd6);
    // reservations then asynchronous reset
    iss(5'd7, 5'd0);
    iss(5'd3, 5'd0);
    mid_reset();
    rd(5'd5, 5'd7, 5'd3);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31),
           2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 7), $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 7),
           ($urandom_range(0, 39) == 0));
      if (i == 700) mid_reset();
    end
    rd(5'd1, 5'd2, 5'd3);

    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
